// File: rtl/wb_rr_intercon.sv
// Shared-bus Wishbone interconnect: round-robin ownership, MSB address decode,
// registered decode-miss error and a per-transfer watchdog that turns a hung target into err.
module wb_rr_intercon #(
    parameter int unsigned               NUM_INIT = 4,
    parameter int unsigned               NUM_TGT  = 4,
    parameter int unsigned               DEC_W    = 8,
    parameter logic [NUM_TGT*DEC_W-1:0]  TGT_BASE = {8'h00, 8'h90, 8'h04, 8'hF0},
    parameter int unsigned               TIMEOUT  = 255
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic [NUM_INIT-1:0]      i_cyc_i,
    input  logic [NUM_INIT-1:0]      i_stb_i,
    input  logic [NUM_INIT-1:0]      i_we_i,
    input  logic [NUM_INIT*32-1:0]   i_adr_i,
    input  logic [NUM_INIT*32-1:0]   i_dat_i,
    input  logic [NUM_INIT*4-1:0]    i_sel_i,
    output logic [31:0]              i_dat_o,
    output logic [NUM_INIT-1:0]      i_ack_o,
    output logic [NUM_INIT-1:0]      i_err_o,
    output logic [NUM_TGT-1:0]       t_cyc_o,
    output logic [NUM_TGT-1:0]       t_stb_o,
    output logic [31:0]              t_adr_o,
    output logic [31:0]              t_dat_o,
    output logic [3:0]               t_sel_o,
    output logic                     t_we_o,
    input  logic [NUM_TGT*32-1:0]    t_dat_i,
    input  logic [NUM_TGT-1:0]       t_ack_i,
    input  logic [NUM_TGT-1:0]       t_err_i,
    output logic [NUM_INIT-1:0]      grant_o,
    output logic                     timeout_o
);

    localparam int unsigned IdxW    = (NUM_INIT > 1) ? $clog2(NUM_INIT) : 1;
    localparam logic [15:0] WdLimit = 16'(TIMEOUT - 1);

    typedef enum logic [0:0] {StIdle, StOwned} state_e;

    state_e              state_q, state_d;
    logic [NUM_INIT-1:0] grant_q, grant_d;
    logic [IdxW-1:0]     last_q, last_d;
    logic [15:0]         wd_cnt_q, wd_cnt_d;
    logic                dec_err_q, dec_err_d;

    logic [IdxW-1:0]     cand, pick_idx;
    logic                pick_found;
    logic                owned, own_cyc, own_stb, own_we;
    logic [31:0]         own_adr, own_dat;
    logic [3:0]          own_sel;
    logic [NUM_TGT-1:0]  hit;
    logic                hit_any, hit_found, tgt_ack, tgt_err;
    logic                wd_run, wd_fire;

    // Rotating scan starting just after the previous owner.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = last_q;
        cand       = '0;
        for (int unsigned k = 1; k <= NUM_INIT; k++) begin
            cand = IdxW'((32'(last_q) + k) % NUM_INIT);
            if (!pick_found && i_cyc_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        owned   = |grant_q;
        own_cyc = |(i_cyc_i & grant_q);
        own_stb = |(i_stb_i & grant_q);
        own_we  = |(i_we_i & grant_q);
        own_adr = '0;
        own_dat = '0;
        own_sel = '0;
        for (int unsigned n = 0; n < NUM_INIT; n++) begin
            if (grant_q[n]) begin
                own_adr = own_adr | i_adr_i[n*32 +: 32];
                own_dat = own_dat | i_dat_i[n*32 +: 32];
                own_sel = own_sel | i_sel_i[n*4 +: 4];
            end
        end
    end

    // Target 0 is the left-most field of TGT_BASE; the lowest matching index wins.
    always_comb begin
        hit       = '0;
        hit_found = 1'b0;
        for (int unsigned t = 0; t < NUM_TGT; t++) begin
            if (owned && !hit_found &&
                own_adr[31 -: DEC_W] == TGT_BASE[(NUM_TGT-1-t)*DEC_W +: DEC_W]) begin
                hit[t]    = 1'b1;
                hit_found = 1'b1;
            end
        end
    end

    always_comb begin
        hit_any = |hit;
        tgt_ack = |(t_ack_i & hit);
        tgt_err = |(t_err_i & hit);
        i_dat_o = '0;
        for (int unsigned t = 0; t < NUM_TGT; t++) begin
            if (hit[t]) begin
                i_dat_o = t_dat_i[t*32 +: 32];
            end
        end
    end

    assign t_cyc_o = hit & {NUM_TGT{own_cyc}};
    assign t_stb_o = hit & {NUM_TGT{own_stb}};
    assign t_adr_o = own_adr;
    assign t_dat_o = own_dat;
    assign t_sel_o = own_sel;
    assign t_we_o  = own_we;

    // A same-cycle ack or err stops the count, so a response always beats the expiry.
    assign wd_run    = own_cyc & own_stb & hit_any & ~tgt_ack & ~tgt_err;
    assign wd_fire   = (TIMEOUT != 0) && wd_run && (wd_cnt_q == WdLimit);
    assign wd_cnt_d  = (wd_run && !wd_fire && TIMEOUT != 0) ? wd_cnt_q + 16'd1 : '0;
    assign dec_err_d = own_cyc & own_stb & ~hit_any & ~dec_err_q;

    assign timeout_o = wd_fire;
    assign grant_o   = grant_q;
    assign i_ack_o   = grant_q & {NUM_INIT{tgt_ack}};
    assign i_err_o   = grant_q & {NUM_INIT{tgt_err | dec_err_q | wd_fire}};

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d           = StOwned;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    last_d            = pick_idx;
                end
            end
            StOwned: begin
                if (!own_cyc) begin
                    state_d = StIdle;
                    grant_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            last_q    <= IdxW'(NUM_INIT - 1);
            wd_cnt_q  <= '0;
            dec_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            wd_cnt_q  <= wd_cnt_d;
            dec_err_q <= dec_err_d;
        end
    end

endmodule

// File: tb/tb_wb_rr_intercon.sv
// Scenario bench for wb_rr_intercon: 4 initiators, 4 targets, watchdog limit of 8 cycles.
module tb_wb_rr_intercon;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   i_cyc, i_stb, i_we;
    logic [127:0] i_adr, i_dat;
    logic [15:0]  i_sel;
    logic [31:0]  i_dat_w;
    logic [3:0]   i_ack_w, i_err_w;
    logic [3:0]   t_cyc_w, t_stb_w;
    logic [31:0]  t_adr_w, t_dat_w;
    logic [3:0]   t_sel_w;
    logic         t_we_w;
    logic [127:0] t_dat_in;
    logic [3:0]   t_ack_in, t_err_in;
    logic [3:0]   grant_w;
    logic         timeout_w;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    wb_rr_intercon #(
        .NUM_INIT (4),
        .NUM_TGT  (4),
        .DEC_W    (8),
        .TGT_BASE ({8'h00, 8'h90, 8'h04, 8'hF0}),
        .TIMEOUT  (8)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .i_cyc_i   (i_cyc),
        .i_stb_i   (i_stb),
        .i_we_i    (i_we),
        .i_adr_i   (i_adr),
        .i_dat_i   (i_dat),
        .i_sel_i   (i_sel),
        .i_dat_o   (i_dat_w),
        .i_ack_o   (i_ack_w),
        .i_err_o   (i_err_w),
        .t_cyc_o   (t_cyc_w),
        .t_stb_o   (t_stb_w),
        .t_adr_o   (t_adr_w),
        .t_dat_o   (t_dat_w),
        .t_sel_o   (t_sel_w),
        .t_we_o    (t_we_w),
        .t_dat_i   (t_dat_in),
        .t_ack_i   (t_ack_in),
        .t_err_i   (t_err_in),
        .grant_o   (grant_w),
        .timeout_o (timeout_w)
    );

    task automatic clear_inputs();
        @(posedge clk); #1;
        i_cyc = '0; i_stb = '0; i_we = '0;
        t_ack_in = '0; t_err_in = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic set_init(input int n, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input logic we);
        i_adr[n*32 +: 32] = adr;
        i_dat[n*32 +: 32] = dat;
        i_sel[n*4 +: 4]   = sel;
        i_we[n]           = we;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_cyc = 4'hF; i_stb = 4'hF; i_we = '0; i_adr = '0; i_dat = '0; i_sel = '0;
        t_ack_in = 4'hF; t_err_in = '0;
        t_dat_in = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        repeat (3) @(posedge clk);
        @(negedge clk);
        vec_cnt++; if (grant_w !== 4'h0) begin err_cnt++; $display("FAIL reset_grant: got %h want 0", grant_w); end
        vec_cnt++; if (t_cyc_w !== 4'h0 || t_stb_w !== 4'h0) begin err_cnt++; $display("FAIL reset_tgt_strobes: got cyc %h stb %h want 0", t_cyc_w, t_stb_w); end
        vec_cnt++; if (i_ack_w !== 4'h0 || i_err_w !== 4'h0) begin err_cnt++; $display("FAIL reset_ack_err: got ack %h err %h want 0", i_ack_w, i_err_w); end
        vec_cnt++; if (timeout_w !== 1'b0) begin err_cnt++; $display("FAIL reset_timeout: got %b want 0", timeout_w); end
        vec_cnt++; if (i_dat_w !== 32'h0 || t_adr_w !== 32'h0) begin err_cnt++; $display("FAIL reset_buses: got dat %h adr %h want 0", i_dat_w, t_adr_w); end
        @(posedge clk); #1;
        rst = 1'b0;
        i_cyc = '0; i_stb = '0; t_ack_in = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        logic [31:0] exp;
        logic [3:0]  g;
        int          budget;
        for (int k = 0; k < 5; k++) sb.push_back(32'(1 << (k % 4)));
        for (int n = 0; n < 4; n++) set_init(n, 32'h0000_0000, 32'h0, 4'hF, 1'b0);
        i_cyc = 4'hF; i_stb = 4'hF;
        budget = 0;
        do begin @(negedge clk); budget++; end while (grant_w === 4'h0 && budget < 10);
        for (int k = 0; k < 5; k++) begin
            exp = sb.pop_front();
            g = grant_w;
            vec_cnt++; if (grant_w !== exp[3:0]) begin err_cnt++; $display("FAIL rr_grant_%0d: got %h want %h", k, grant_w, exp[3:0]); end
            vec_cnt++; if (t_stb_w !== 4'b0001) begin err_cnt++; $display("FAIL rr_tstb_%0d: got %h want 1", k, t_stb_w); end
            t_ack_in = 4'b0001; #1;
            vec_cnt++; if (i_ack_w !== exp[3:0]) begin err_cnt++; $display("FAIL rr_ack_%0d: got %h want %h", k, i_ack_w, exp[3:0]); end
            @(posedge clk); #1;
            t_ack_in = '0; i_cyc = i_cyc & ~g; i_stb = i_stb & ~g;
            @(posedge clk); #1;
            i_cyc = i_cyc | g; i_stb = i_stb | g;
            @(negedge clk);
            vec_cnt++; if (grant_w !== 4'h0) begin err_cnt++; $display("FAIL rr_idle_gap_%0d: got %h want 0", k, grant_w); end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic test_read();
        logic [31:0] exp;
        sb.push_back(32'hDEAD_BEEF);
        set_init(1, 32'h9000_0010, 32'h0, 4'hF, 1'b0);
        i_cyc = 4'b0010; i_stb = 4'b0010;
        @(negedge clk);
        vec_cnt++; if (grant_w !== 4'h0) begin err_cnt++; $display("FAIL read_grant_latency: got %h want 0", grant_w); end
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            vec_cnt++; if (grant_w !== 4'b0010 || t_stb_w !== 4'b0010 || t_cyc_w !== 4'b0010) begin err_cnt++; $display("FAIL read_route_%0d: got grant %h stb %h cyc %h want 2", w, grant_w, t_stb_w, t_cyc_w); end
            vec_cnt++; if (i_ack_w !== 4'h0 || t_adr_w !== 32'h9000_0010) begin err_cnt++; $display("FAIL read_wait_%0d: got ack %h adr %h want 0 / 90000010", w, i_ack_w, t_adr_w); end
            @(posedge clk); #1;
        end
        t_ack_in = 4'b0010; t_dat_in[63:32] = 32'hDEAD_BEEF;
        @(negedge clk);
        exp = sb.pop_front();
        vec_cnt++; if (i_ack_w !== 4'b0010) begin err_cnt++; $display("FAIL read_ack: got %h want 2", i_ack_w); end
        vec_cnt++; if (i_dat_w !== exp) begin err_cnt++; $display("FAIL read_data: got %h want %h", i_dat_w, exp); end
        @(posedge clk); #1;
        t_ack_in = '0; i_cyc = '0; i_stb = '0;
        @(negedge clk);
        vec_cnt++; if (i_ack_w !== 4'h0) begin err_cnt++; $display("FAIL read_ack_single: got %h want 0", i_ack_w); end
        clear_inputs();
    endtask

    task automatic test_write();
        set_init(3, 32'h0400_0004, 32'hA5A5_5A5A, 4'b0011, 1'b1);
        i_cyc = 4'b1000; i_stb = 4'b1000;
        @(posedge clk);
        @(negedge clk);
        vec_cnt++; if (grant_w !== 4'b1000 || t_stb_w !== 4'b0100) begin err_cnt++; $display("FAIL write_route: got grant %h stb %h want 8 / 4", grant_w, t_stb_w); end
        vec_cnt++; if (t_dat_w !== 32'hA5A5_5A5A || t_sel_w !== 4'b0011 || t_we_w !== 1'b1) begin err_cnt++; $display("FAIL write_bus: got dat %h sel %h we %b want a5a55a5a / 3 / 1", t_dat_w, t_sel_w, t_we_w); end
        t_ack_in = 4'b0100; #1;
        vec_cnt++; if (i_ack_w !== 4'b1000) begin err_cnt++; $display("FAIL write_ack: got %h want 8", i_ack_w); end
        clear_inputs();
    endtask

    task automatic test_decode_err();
        logic [31:0] exp;
        sb.push_back(32'h4);
        set_init(2, 32'h5000_0000, 32'h0, 4'hF, 1'b0);
        i_cyc = 4'b0100; i_stb = 4'b0100;
        @(posedge clk);
        @(negedge clk);
        vec_cnt++; if (grant_w !== 4'b0100 || t_stb_w !== 4'h0 || t_cyc_w !== 4'h0) begin err_cnt++; $display("FAIL decerr_no_strobe: got grant %h stb %h cyc %h want 4 / 0 / 0", grant_w, t_stb_w, t_cyc_w); end
        vec_cnt++; if (i_err_w !== 4'h0) begin err_cnt++; $display("FAIL decerr_early: got %h want 0", i_err_w); end
        @(negedge clk);
        exp = sb.pop_front();
        vec_cnt++; if (i_err_w !== exp[3:0]) begin err_cnt++; $display("FAIL decerr_pulse: got %h want %h", i_err_w, exp[3:0]); end
        @(negedge clk);
        vec_cnt++; if (i_err_w !== 4'h0) begin err_cnt++; $display("FAIL decerr_width: got %h want 0", i_err_w); end
        clear_inputs();
    endtask

    task automatic test_watchdog();
        logic pulse;
        set_init(3, 32'hF000_0000, 32'h0, 4'hF, 1'b0);
        i_cyc = 4'b1000; i_stb = 4'b1000;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            pulse = (k == 8) || (k == 16);
            vec_cnt++; if (timeout_w !== pulse) begin err_cnt++; $display("FAIL wd_timeout_c%0d: got %b want %b", k, timeout_w, pulse); end
            vec_cnt++; if (i_err_w !== (pulse ? 4'b1000 : 4'b0000)) begin err_cnt++; $display("FAIL wd_err_c%0d: got %h want %h", k, i_err_w, pulse ? 4'b1000 : 4'b0000); end
        end
        clear_inputs();
    endtask

    task automatic test_ack_at_expiry();
        set_init(0, 32'hF000_0000, 32'h0, 4'hF, 1'b0);
        i_cyc = 4'b0001; i_stb = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == 8) t_ack_in = 4'b1000;
            @(negedge clk);
            vec_cnt++; if (timeout_w !== 1'b0) begin err_cnt++; $display("FAIL ackwin_timeout_c%0d: got %b want 0", k, timeout_w); end
        end
        vec_cnt++; if (i_ack_w !== 4'b0001 || i_err_w !== 4'h0) begin err_cnt++; $display("FAIL ackwin_resp: got ack %h err %h want 1 / 0", i_ack_w, i_err_w); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] exp;
        sb.push_back(32'h1);
        for (int n = 0; n < 4; n++) set_init(n, 32'h0000_0000, 32'h0, 4'hF, 1'b0);
        i_cyc = 4'b0100; i_stb = 4'b0100;
        @(posedge clk); #1;
        i_cyc = 4'hF; i_stb = 4'hF; t_ack_in = 4'b0001;
        @(negedge clk);
        vec_cnt++; if (grant_w !== 4'b0100 || i_ack_w !== 4'b0100) begin err_cnt++; $display("FAIL rstmid_owner: got grant %h ack %h want 4 / 4", grant_w, i_ack_w); end
        @(negedge clk);
        vec_cnt++; if (grant_w !== 4'b0100) begin err_cnt++; $display("FAIL rstmid_hold: got %h want 4", grant_w); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        vec_cnt++; if (grant_w !== 4'h0 || t_stb_w !== 4'h0 || t_cyc_w !== 4'h0) begin err_cnt++; $display("FAIL rstmid_clear: got grant %h stb %h cyc %h want 0", grant_w, t_stb_w, t_cyc_w); end
        vec_cnt++; if (i_ack_w !== 4'h0 || timeout_w !== 1'b0) begin err_cnt++; $display("FAIL rstmid_ack_drop: got ack %h timeout %b want 0", i_ack_w, timeout_w); end
        @(negedge clk);
        exp = sb.pop_front();
        vec_cnt++; if (grant_w !== exp[3:0] || t_stb_w !== 4'b0001) begin err_cnt++; $display("FAIL rstmid_first_grant: got grant %h stb %h want %h / 1", grant_w, t_stb_w, exp[3:0]); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_read();
        test_write();
        test_decode_err();
        test_watchdog();
        test_ack_at_expiry();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/wb_rr_intercon.md
# wb_rr_intercon

Parametrised shared-bus Wishbone interconnect: the next generation of the fixed 8-initiator / 9-target traffic cop. It supports NUM_INIT initiators and NUM_TGT targets, both set at elaboration. Ownership is granted round-robin instead of by fixed priority. It adds a per-transfer watchdog that converts a hung target into an `err` response. It sits between the OR1200 instruction/data masters plus the debug master and the memory and peripheral slaves (SRAM controller, UART16550, …).

## Interface
Parameters:
- NUM_INIT, 4: number of initiators (2–8).
- NUM_TGT, 4: number of targets (2–8).
- DEC_W, 8: number of address MSBs used for decode, adr[31:32-DEC_W].
- TGT_BASE, {8'h00,8'h90,8'h04,8'hF0}: packed NUM_TGT×DEC_W vector. Field t is the decode value of target t.
- TIMEOUT, 255: watchdog limit in cycles (1–65535). 0 disables the watchdog.

Ports:
- wb_clk_i  in  1  system clock; every register updates on its rising edge.
- wb_rst_i  in  1  reset, synchronous and active-high.
- i_cyc_i / i_stb_i / i_we_i  in  NUM_INIT each  per-initiator cycle, strobe and write enable.
- i_adr_i / i_dat_i  in  NUM_INIT×32  flattened addresses / write data. Initiator n occupies bits [32n+31:32n].
- i_sel_i  in  NUM_INIT×4  flattened byte selects.
- i_dat_o  out  32  read data, broadcast to all initiators.
- i_ack_o / i_err_o  out  NUM_INIT  per-initiator ack / err.
- t_cyc_o / t_stb_o  out  NUM_TGT  per-target cycle / strobe.
- t_adr_o 32, t_dat_o 32, t_sel_o 4, t_we_o 1  out  shared target address, write data, byte selects and write enable.
- t_dat_i  in  NUM_TGT×32  flattened target read data.
- t_ack_i / t_err_i  in  NUM_TGT  per-target ack / err.
- grant_o  out  NUM_INIT  one-hot current owner.
- timeout_o  out  1  one-cycle pulse when the watchdog fires.

## Operation
- Arbiter FSM, two states, IDLE and OWNED. Register `last` holds the index of the previous owner.
- IDLE with any i_cyc_i high:
  - Pick the first requester scanning last+1, last+2, … with wrap modulo NUM_INIT.
  - Load grant_o and `last`, move to OWNED.
- OWNED with the owner's i_cyc_i low: clear grant_o, return to IDLE.
  - Non-owner requests are ignored until the owner releases.
  - The owner's cyc may stay high across many transfers (block/RMW); ownership is kept throughout.
- Routing, all combinational from grant_o:
  - The owner's adr/dat/sel/we drive the t_* buses. These buses are 0 when no owner.
  - Decode: target t is hit when adr[31:32-DEC_W] == TGT_BASE[t]. On overlap the lowest t wins.
  - t_cyc_o[t] = owner cyc & hit. t_stb_o[t] = owner stb & hit.
  - i_dat_o = t_dat_i of the hit target, else 0.
  - Owner i_ack_o = hit target's t_ack_i. Owner i_err_o = t_err_i | decode_err | wd_err.
- Decode miss: owner stb high with no hit.
  - No target is strobed.
  - Registered decode_err asserts 1 cycle after stb rises, lasts exactly 1 cycle, then rearms while stb stays high.
- Watchdog: 16-bit counter.
  - Increments each cycle the owner's stb is high to a hit target with no ack/err.
  - Clears on ack, err, stb low, or ownership change.
  - At count == TIMEOUT-1: wd_err and timeout_o pulse for 1 cycle; the counter clears.
  - An ack arriving in the same cycle as the expiry wins: ack passes, no err, no pulse.

## Timing
- Reset values: grant_o=0, last=NUM_INIT-1 (initiator 0 wins first), state IDLE, counter 0, timeout_o=0, decode_err=0. All t_cyc_o/t_stb_o/i_ack_o/i_err_o are 0.
- Reset asserted mid-transfer: all of the above on the next edge. An in-flight target ack is dropped.
- Grant latency: request in cycle N → grant_o and t_cyc_o valid in cycle N+1.
- Release: cyc low in cycle M → grant_o=0 at M+1. The next owner is granted at M+2 (one idle cycle minimum).
- Target ack is combinational to the initiator (0 added cycles). Decode err takes 1 cycle. Watchdog err arrives TIMEOUT cycles after stb, counting the stb cycle as 1.
- Simultaneous requests in IDLE resolve strictly by rotation. No initiator waits more than NUM_INIT-1 tenures.

## Test plan
- Reset, then i_cyc_i=4'b1111 held, each owner releasing after one transfer → grant order 0,1,2,3,0. Two cycles between successive grants.
- Initiator 1 reads 0x9000_0010 and target 1 acks after 3 waits with 0xDEADBEEF → i_dat_o=0xDEADBEEF, i_ack_o=4'b0010 for 1 cycle, only t_stb_o[1] high.
- Access to 0x5000_0000 (no match) → i_err_o pulses 1 cycle after stb, no t_stb_o asserted.
- TIMEOUT=8, target never responds → i_err_o and timeout_o pulse at the 8th stb cycle. A second pulse follows 8 cycles later if stb is held.
- TIMEOUT=8, ack on the 8th cycle → ack only, timeout_o stays 0.
- wb_rst_i for 1 cycle during an OWNED burst → grant_o=0, all strobes 0 next cycle. Initiator 0 is granted first afterward.
